// File: rtl/mc_control_fsm.sv
// Main control FSM of the RV32I multi-cycle core: sequences fetch/decode/execute/
// memory/write-back and drives datapath selects, write strobes and alu_op.
module mc_control_fsm (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [6:0] opcode,
  input  logic       mem_ready,
  input  logic       br_taken,
  output logic       pc_write,
  output logic       pc_lsb_clr,
  output logic       ir_write,
  output logic       mem_read,
  output logic       mem_write,
  output logic       adr_src,
  output logic       reg_write,
  output logic [1:0] alu_src_a,
  output logic [1:0] alu_src_b,
  output logic [1:0] result_src,
  output logic [1:0] alu_op,
  output logic       instr_retired,
  output logic       illegal_instr,
  output logic [3:0] state
);

  // state     | meaning
  // FETCH     | read instruction at PC, PC += 4 on mem_ready
  // DECODE    | branch/JAL target into ALUOut, dispatch on opcode
  // MEM_ADDR  | rs1 + imm load/store address
  // MEM_RD    | load data request
  // MEM_WB    | load data to register file
  // MEM_WR    | store data request
  // EXEC_R    | rs1 op rs2
  // EXEC_I    | rs1 op imm
  // ALU_WB    | ALUOut to register file
  // BRANCH    | compare, load PC from ALUOut when taken
  // JAL       | jump to target, link into ALUOut
  // JALR_CALC | rs1 + imm target
  // JALR_JMP  | jump with bit 0 cleared, link into ALUOut
  // LUI       | 0 + imm
  // AUIPC     | old_pc + imm
  // TRAP      | illegal opcode, held until reset
  typedef enum logic [3:0] {
    S_FETCH     = 4'd0,
    S_DECODE    = 4'd1,
    S_MEM_ADDR  = 4'd2,
    S_MEM_RD    = 4'd3,
    S_MEM_WB    = 4'd4,
    S_MEM_WR    = 4'd5,
    S_EXEC_R    = 4'd6,
    S_EXEC_I    = 4'd7,
    S_ALU_WB    = 4'd8,
    S_BRANCH    = 4'd9,
    S_JAL       = 4'd10,
    S_JALR_CALC = 4'd11,
    S_JALR_JMP  = 4'd12,
    S_LUI       = 4'd13,
    S_AUIPC     = 4'd14,
    S_TRAP      = 4'd15
  } state_t;

  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_RTYPE  = 7'b0110011;
  localparam logic [6:0] OP_ITYPE  = 7'b0010011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] OP_FENCE  = 7'b0001111;

  // Per-state control word. The *_rdy / *_br / *_fence bits mark outputs that are
  // qualified in the same cycle by mem_ready, br_taken or the opcode.
  typedef struct packed {
    logic       pc_write;
    logic       pc_wr_rdy;
    logic       pc_wr_br;
    logic       pc_lsb_clr;
    logic       ir_wr_rdy;
    logic       mem_read;
    logic       mem_write;
    logic       adr_src;
    logic       reg_write;
    logic [1:0] alu_src_a;
    logic [1:0] alu_src_b;
    logic [1:0] result_src;
    logic [1:0] alu_op;
    logic       retire;
    logic       retire_rdy;
    logic       retire_fence;
    logic       illegal;
  } ctl_t;

  function automatic ctl_t decode(state_t s);
    ctl_t c;
    c = '0;
    case (s)
      S_FETCH: begin
        c.mem_read   = 1'b1;
        c.alu_src_b  = 2'b10;
        c.result_src = 2'b10;
        c.pc_wr_rdy  = 1'b1;
        c.ir_wr_rdy  = 1'b1;
      end
      S_DECODE: begin
        c.alu_src_a    = 2'b01;
        c.alu_src_b    = 2'b01;
        c.retire_fence = 1'b1;
      end
      S_MEM_ADDR: begin
        c.alu_src_a = 2'b10;
        c.alu_src_b = 2'b01;
      end
      S_MEM_RD: begin
        c.mem_read = 1'b1;
        c.adr_src  = 1'b1;
      end
      S_MEM_WB: begin
        c.reg_write  = 1'b1;
        c.result_src = 2'b01;
        c.retire     = 1'b1;
      end
      S_MEM_WR: begin
        c.mem_write  = 1'b1;
        c.adr_src    = 1'b1;
        c.retire_rdy = 1'b1;
      end
      S_EXEC_R: begin
        c.alu_src_a = 2'b10;
        c.alu_op    = 2'b10;
      end
      S_EXEC_I: begin
        c.alu_src_a = 2'b10;
        c.alu_src_b = 2'b01;
        c.alu_op    = 2'b11;
      end
      S_ALU_WB: begin
        c.reg_write = 1'b1;
        c.retire    = 1'b1;
      end
      S_BRANCH: begin
        c.alu_src_a = 2'b10;
        c.alu_op    = 2'b01;
        c.pc_wr_br  = 1'b1;
        c.retire    = 1'b1;
      end
      S_JAL: begin
        c.pc_write  = 1'b1;
        c.alu_src_a = 2'b01;
        c.alu_src_b = 2'b10;
      end
      S_JALR_CALC: begin
        c.alu_src_a = 2'b10;
        c.alu_src_b = 2'b01;
      end
      S_JALR_JMP: begin
        c.pc_write   = 1'b1;
        c.pc_lsb_clr = 1'b1;
        c.alu_src_a  = 2'b01;
        c.alu_src_b  = 2'b10;
      end
      S_LUI: begin
        c.alu_src_a = 2'b11;
        c.alu_src_b = 2'b01;
      end
      S_AUIPC: begin
        c.alu_src_a = 2'b01;
        c.alu_src_b = 2'b01;
      end
      S_TRAP: c.illegal = 1'b1;
      default: c = '0;
    endcase
    return c;
  endfunction

  state_t st_q, nxt;
  ctl_t   ctl_q;

  always_comb begin
    nxt = st_q;
    case (st_q)
      S_FETCH:  nxt = mem_ready ? S_DECODE : S_FETCH;
      S_DECODE: begin
        case (opcode)
          OP_LOAD, OP_STORE: nxt = S_MEM_ADDR;
          OP_RTYPE:          nxt = S_EXEC_R;
          OP_ITYPE:          nxt = S_EXEC_I;
          OP_BRANCH:         nxt = S_BRANCH;
          OP_JAL:            nxt = S_JAL;
          OP_JALR:           nxt = S_JALR_CALC;
          OP_LUI:            nxt = S_LUI;
          OP_AUIPC:          nxt = S_AUIPC;
          OP_FENCE:          nxt = S_FETCH;
          default:           nxt = S_TRAP;
        endcase
      end
      S_MEM_ADDR:  nxt = opcode[5] ? S_MEM_WR : S_MEM_RD;
      S_MEM_RD:    nxt = mem_ready ? S_MEM_WB : S_MEM_RD;
      S_MEM_WB:    nxt = S_FETCH;
      S_MEM_WR:    nxt = mem_ready ? S_FETCH : S_MEM_WR;
      S_EXEC_R:    nxt = S_ALU_WB;
      S_EXEC_I:    nxt = S_ALU_WB;
      S_ALU_WB:    nxt = S_FETCH;
      S_BRANCH:    nxt = S_FETCH;
      S_JAL:       nxt = S_ALU_WB;
      S_JALR_CALC: nxt = S_JALR_JMP;
      S_JALR_JMP:  nxt = S_ALU_WB;
      S_LUI:       nxt = S_ALU_WB;
      S_AUIPC:     nxt = S_ALU_WB;
      S_TRAP:      nxt = S_TRAP;
      default:     nxt = S_FETCH;
    endcase
  end

  // Control word is registered from the next state so outputs come straight off flops.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      st_q  <= S_FETCH;
      ctl_q <= decode(S_FETCH);
    end else begin
      st_q  <= nxt;
      ctl_q <= decode(nxt);
    end
  end

  // Strobes are gated by rst_n so a reset cycle never commits architectural state.
  assign pc_write      = rst_n & (ctl_q.pc_write | (ctl_q.pc_wr_rdy & mem_ready)
                                  | (ctl_q.pc_wr_br & br_taken));
  assign ir_write      = rst_n & ctl_q.ir_wr_rdy & mem_ready;
  assign mem_read      = rst_n & ctl_q.mem_read;
  assign mem_write     = rst_n & ctl_q.mem_write;
  assign reg_write     = rst_n & ctl_q.reg_write;
  assign instr_retired = rst_n & (ctl_q.retire | (ctl_q.retire_rdy & mem_ready)
                                  | (ctl_q.retire_fence & (opcode == OP_FENCE)));
  assign pc_lsb_clr    = ctl_q.pc_lsb_clr;
  assign adr_src       = ctl_q.adr_src;
  assign alu_src_a     = ctl_q.alu_src_a;
  assign alu_src_b     = ctl_q.alu_src_b;
  assign result_src    = ctl_q.result_src;
  assign alu_op        = ctl_q.alu_op;
  assign illegal_instr = ctl_q.illegal;
  assign state         = st_q;

endmodule

// File: tb/tb_mc_control_fsm.sv
// Self-checking bench for mc_control_fsm: per-instruction expected cycle lists built
// from the instruction class, checked cycle by cycle against the DUT outputs.
module tb_mc_control_fsm;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [6:0] opcode = 7'b0;
  logic       mem_ready = 1'b0;
  logic       br_taken = 1'b0;
  logic       pc_write, pc_lsb_clr, ir_write, mem_read, mem_write, adr_src, reg_write;
  logic [1:0] alu_src_a, alu_src_b, result_src, alu_op;
  logic       instr_retired, illegal_instr;
  logic [3:0] state;

  int tests = 0;
  int fails = 0;

  mc_control_fsm dut (
    .clk(clk), .rst_n(rst_n), .opcode(opcode), .mem_ready(mem_ready), .br_taken(br_taken),
    .pc_write(pc_write), .pc_lsb_clr(pc_lsb_clr), .ir_write(ir_write), .mem_read(mem_read),
    .mem_write(mem_write), .adr_src(adr_src), .reg_write(reg_write), .alu_src_a(alu_src_a),
    .alu_src_b(alu_src_b), .result_src(result_src), .alu_op(alu_op),
    .instr_retired(instr_retired), .illegal_instr(illegal_instr), .state(state)
  );

  always #5 clk = ~clk;

  localparam logic [6:0] LD = 7'b0000011, SW = 7'b0100011, RT = 7'b0110011, IT = 7'b0010011;
  localparam logic [6:0] BR = 7'b1100011, JL = 7'b1101111, JR = 7'b1100111, LU = 7'b0110111;
  localparam logic [6:0] AU = 7'b0010111, FE = 7'b0001111;

  // One expected cycle: stimulus to apply (rdy, br) and outputs required.
  typedef struct packed {
    logic [3:0] st;
    logic       rdy, br;
    logic       pcw, lsb, irw, mrd, mwr, adr, rw, ret;
    logic [1:0] a, b, rs, op;
    logic       ill;
  } cyc_t;

  cyc_t exp_q[$];

  function automatic cyc_t phase(int st, logic rdy, logic br, logic fence);
    cyc_t c;
    c = '0;
    c.st = 4'(st); c.rdy = rdy; c.br = br;
    case (st)
      0:  begin c.mrd = 1; c.b = 2'b10; c.rs = 2'b10; c.irw = rdy; c.pcw = rdy; end
      1:  begin c.a = 2'b01; c.b = 2'b01; c.ret = fence; end
      2:  begin c.a = 2'b10; c.b = 2'b01; end
      3:  begin c.mrd = 1; c.adr = 1; end
      4:  begin c.rw = 1; c.rs = 2'b01; c.ret = 1; end
      5:  begin c.mwr = 1; c.adr = 1; c.ret = rdy; end
      6:  begin c.a = 2'b10; c.op = 2'b10; end
      7:  begin c.a = 2'b10; c.b = 2'b01; c.op = 2'b11; end
      8:  begin c.rw = 1; c.ret = 1; end
      9:  begin c.a = 2'b10; c.op = 2'b01; c.ret = 1; c.pcw = br; end
      10: begin c.pcw = 1; c.a = 2'b01; c.b = 2'b10; end
      11: begin c.a = 2'b10; c.b = 2'b01; end
      12: begin c.pcw = 1; c.lsb = 1; c.a = 2'b01; c.b = 2'b10; end
      13: begin c.a = 2'b11; c.b = 2'b01; end
      14: begin c.a = 2'b01; c.b = 2'b01; end
      default: c.ill = 1;
    endcase
    return c;
  endfunction

  function automatic logic rnd();
    return 1'($urandom);
  endfunction

  // Expected cycle list for one instruction: wf fetch waits, wd data waits.
  task automatic build(input logic [6:0] op, input int wf, input int wd, input logic br);
    for (int i = 0; i < wf; i++) exp_q.push_back(phase(0, 0, rnd(), 0));
    exp_q.push_back(phase(0, 1, rnd(), 0));
    exp_q.push_back(phase(1, rnd(), rnd(), op == FE));
    case (op)
      LD: begin
        exp_q.push_back(phase(2, rnd(), rnd(), 0));
        for (int i = 0; i < wd; i++) exp_q.push_back(phase(3, 0, rnd(), 0));
        exp_q.push_back(phase(3, 1, rnd(), 0));
        exp_q.push_back(phase(4, rnd(), rnd(), 0));
      end
      SW: begin
        exp_q.push_back(phase(2, rnd(), rnd(), 0));
        for (int i = 0; i < wd; i++) exp_q.push_back(phase(5, 0, rnd(), 0));
        exp_q.push_back(phase(5, 1, rnd(), 0));
      end
      RT: begin exp_q.push_back(phase(6, rnd(), rnd(), 0)); exp_q.push_back(phase(8, rnd(), rnd(), 0)); end
      IT: begin exp_q.push_back(phase(7, rnd(), rnd(), 0)); exp_q.push_back(phase(8, rnd(), rnd(), 0)); end
      BR: exp_q.push_back(phase(9, rnd(), br, 0));
      JL: begin exp_q.push_back(phase(10, rnd(), rnd(), 0)); exp_q.push_back(phase(8, rnd(), rnd(), 0)); end
      JR: begin
        exp_q.push_back(phase(11, rnd(), rnd(), 0));
        exp_q.push_back(phase(12, rnd(), rnd(), 0));
        exp_q.push_back(phase(8, rnd(), rnd(), 0));
      end
      LU: begin exp_q.push_back(phase(13, rnd(), rnd(), 0)); exp_q.push_back(phase(8, rnd(), rnd(), 0)); end
      AU: begin exp_q.push_back(phase(14, rnd(), rnd(), 0)); exp_q.push_back(phase(8, rnd(), rnd(), 0)); end
      FE: ;
      default: exp_q.push_back(phase(15, rnd(), rnd(), 0));
    endcase
  endtask

  function automatic logic [20:0] expv(cyc_t c);
    return {c.st, c.pcw, c.lsb, c.irw, c.mrd, c.mwr, c.adr, c.rw, c.ret, c.a, c.b, c.rs, c.op, c.ill};
  endfunction

  // Runs up to n queued cycles (entered and left just after a rising edge), then drops the rest.
  task automatic run_q(input string name, input int n);
    int k = 0;
    while (exp_q.size() > 0 && k < n) begin
      cyc_t c = exp_q.pop_front();
      logic [20:0] act;
      mem_ready = c.rdy;
      br_taken  = c.br;
      @(negedge clk);
      act = {state, pc_write, pc_lsb_clr, ir_write, mem_read, mem_write, adr_src, reg_write,
             instr_retired, alu_src_a, alu_src_b, result_src, alu_op, illegal_instr};
      tests++;
      if (act !== expv(c)) begin
        fails++;
        $display("FAIL %s cyc%0d: got st=%0d ctl=%h, expected st=%0d ctl=%h",
                 name, k, act[20:17], act, c.st, expv(c));
      end
      @(posedge clk); #1;
      k++;
    end
    exp_q.delete();
  endtask

  task automatic check_no_strobes(input string name);
    logic [5:0] s;
    @(negedge clk);
    s = {pc_write, ir_write, mem_read, mem_write, reg_write, instr_retired};
    tests++;
    if (s !== 6'b0) begin
      fails++;
      $display("FAIL %s: strobes got %b, expected 000000", name, s);
    end
  endtask

  task automatic check_restart(input string name);
    @(negedge clk);
    tests++;
    if (state !== 4'd0 || illegal_instr !== 1'b0) begin
      fails++;
      $display("FAIL %s: got state=%0d illegal=%b, expected state=0 illegal=0", name, state, illegal_instr);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_reset();
    rst_n = 0; mem_ready = 1; br_taken = 1; opcode = RT;
    repeat (2) begin
      check_no_strobes("reset_strobes");
      @(posedge clk); #1;
    end
    rst_n = 1; mem_ready = 0;
    check_restart("reset_state");
  endtask

  task automatic test_add();
    opcode = RT; build(RT, 0, 0, 0); run_q("add", 100);
  endtask

  task automatic test_load_wait();
    opcode = LD; build(LD, 0, 2, 0); run_q("lw_wait", 100);
    opcode = SW; build(SW, 1, 2, 0); run_q("sw_wait", 100);
  endtask

  task automatic test_branch();
    opcode = BR; build(BR, 0, 0, 1); run_q("beq_taken", 100);
    build(BR, 0, 0, 0); run_q("beq_not_taken", 100);
  endtask

  task automatic test_jumps();
    opcode = JR; build(JR, 0, 0, 0); run_q("jalr", 100);
    opcode = JL; build(JL, 0, 0, 0); run_q("jal", 100);
    opcode = FE; build(FE, 0, 0, 0); run_q("fence", 100);
  endtask

  task automatic test_back_to_back();
    logic [6:0] ops [10] = '{LD, SW, RT, IT, BR, JL, JR, LU, AU, FE};
    for (int i = 0; i < 150; i++) begin
      logic [6:0] op = ops[$urandom_range(0, 9)];
      opcode = op;
      build(op, $urandom_range(0, 3), $urandom_range(0, 3), rnd());
      run_q($sformatf("rand%0d_op%b", i, op), 100);
    end
  endtask

  task automatic test_trap(input logic [6:0] op);
    opcode = op;
    build(op, 0, 0, 0);
    for (int i = 0; i < 19; i++) exp_q.push_back(phase(15, rnd(), rnd(), 0));
    run_q($sformatf("trap_%b", op), 100);
    rst_n = 0;
    check_no_strobes("trap_reset_strobes");
    @(posedge clk); #1;
    rst_n = 1; mem_ready = 0;
    check_restart("trap_reset_state");
  endtask

  task automatic test_reset_midstore();
    opcode = SW;
    build(SW, 0, 0, 0);
    run_q("midstore_pre", 3);
    rst_n = 0; mem_ready = 1;
    @(negedge clk);
    tests++;
    if (state !== 4'd5 || mem_write !== 1'b0 || instr_retired !== 1'b0) begin
      fails++;
      $display("FAIL midstore_reset: got state=%0d mem_write=%b retired=%b, expected 5/0/0",
               state, mem_write, instr_retired);
    end
    @(posedge clk); #1;
    rst_n = 1; mem_ready = 0;
    check_restart("midstore_restart");
    opcode = IT; build(IT, 0, 0, 0); run_q("after_midstore", 100);
  endtask

  initial begin
    test_reset();
    test_add();
    test_load_wait();
    test_branch();
    test_jumps();
    test_back_to_back();
    test_trap(7'b1111111);
    test_trap(7'b1110011);
    test_reset_midstore();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
